// File: rtl/embedding_loader.sv
// Packs a stream of IEEE-754 words into probe/enrolled vectors, kicks the dot-product MAC,
// and returns its result over valid/ready. Optional NaN/Inf screening under EMB_NAN_CHECK_EN.
module embedding_loader #(
  parameter int unsigned D_Len   = 32,
  parameter int unsigned Ele_Num = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [D_Len-1:0]         s_data,
  output logic [D_Len*Ele_Num-1:0] v1,
  output logic [D_Len*Ele_Num-1:0] v2,
  output logic                     mac_start,
  input  logic                     mac_done,
  input  logic [D_Len-1:0]         mac_result,
  output logic                     sim_valid,
  input  logic                     sim_ready,
  output logic [D_Len-1:0]         sim_result,
  output logic                     sim_err
);

  localparam int unsigned WORDS = 2 * Ele_Num;
  localparam int unsigned CW    = $clog2(WORDS) + 1;
  localparam int unsigned VW    = D_Len * Ele_Num;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [D_Len-1:0] QNAN = D_Len'(32'h7FC0_0000);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             sim_err_q, sim_err_d;
  logic [D_Len-1:0] res_q, res_d;
  logic [VW-1:0]    v1_q, v2_q;
  logic             mac_start_q, sim_valid_q;
  logic             accept, wr_en, last_word, word_nan;

  // Ready is forced low while reset is held, even though state already reads LOAD.
  assign s_ready   = rst && (state_q == S_LOAD);
  assign accept    = s_valid && s_ready;
  assign wr_en     = accept && !clr;
  assign last_word = (cnt_q == CW'(WORDS - 1));

`ifdef EMB_NAN_CHECK_EN
  assign word_nan = &s_data[D_Len-2:D_Len-9];
`else
  assign word_nan = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    err_d     = err_q;
    sim_err_d = sim_err_q;
    res_d     = res_q;
    case (state_q)
      S_LOAD: begin
        if (clr) begin
          cnt_d = '0;
          err_d = 1'b0;
        end else if (accept) begin
          if (word_nan) err_d = 1'b1;
          if (last_word) begin
            cnt_d = '0;
            if (err_q || word_nan) begin
              state_d   = S_OUT;
              res_d     = QNAN;
              sim_err_d = 1'b1;
            end else begin
              state_d = S_START;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        first_d = 1'b1;
      end
      // First WAIT cycle skips a done level that may still be left over from the prior run.
      S_WAIT: begin
        if (!first_q && mac_done) begin
          res_d   = mac_result;
          state_d = S_OUT;
        end
      end
      default: begin
        if (sim_ready) begin
          state_d   = S_LOAD;
          sim_err_d = 1'b0;
          err_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      sim_err_q   <= 1'b0;
      res_q       <= '0;
      mac_start_q <= 1'b0;
      sim_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      err_q       <= err_d;
      sim_err_q   <= sim_err_d;
      res_q       <= res_d;
      mac_start_q <= (state_d == S_START);
      sim_valid_q <= (state_d == S_OUT);
    end
  end

  // Vectors change only on accepted LOAD words, so they hold steady for the MAC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= '0;
      v2_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(Ele_Num); i++) begin
        if (cnt_q == CW'(i)) v1_q[i*D_Len +: D_Len] <= s_data;
        if (cnt_q == CW'(i + int'(Ele_Num))) v2_q[i*D_Len +: D_Len] <= s_data;
      end
    end
  end

  assign v1         = v1_q;
  assign v2         = v2_q;
  assign mac_start  = mac_start_q;
  assign sim_valid  = sim_valid_q;
  assign sim_result = res_q;
  assign sim_err    = sim_err_q;

endmodule

// File: tb/tb_embedding_loader.sv
// Randomized bench for embedding_loader: a behavioural model checks every cycle,
// a simple FP MAC model answers mac_start, and literal checks pin key results.
module tb_embedding_loader;
  localparam int unsigned DL = 32;
  localparam int unsigned EN = 128;
  localparam int unsigned NW = 2 * EN;
  localparam int unsigned VW = DL * EN;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DL-1:0] s_data = '0;
  logic [VW-1:0] v1, v2;
  logic          mac_start;
  logic          mac_done = 1'b0;
  logic [DL-1:0] mac_result = '0;
  logic          sim_valid;
  logic          sim_ready = 1'b0;
  logic [DL-1:0] sim_result;
  logic          sim_err;

  embedding_loader #(.D_Len(DL), .Ele_Num(EN)) dut (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .v1(v1), .v2(v2), .mac_start(mac_start), .mac_done(mac_done),
    .mac_result(mac_result), .sim_valid(sim_valid), .sim_ready(sim_ready),
    .sim_result(sim_result), .sim_err(sim_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_start = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [DL-1:0] m [EN]);
    int bad;
    logic [DL-1:0] a;
    bad = -1;
    for (int i = 0; i < int'(EN); i++) begin
      a = act[i*DL +: DL];
      if (bad < 0 && a !== m[i]) bad = i;
    end
    n_vec++;
    if (bad >= 0) begin
      n_bad++;
      a = act[bad*DL +: DL];
      $display("FAIL %s elem %0d: got %h expected %h", name, bad, a, m[bad]);
    end
  endtask

  // ---------------- IEEE-754 helpers for the MAC model ----------------
  function automatic real b2f(input logic [31:0] b);
    int  e;
    real r;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] f2b(input real r);
    logic [63:0] x;
    int e;
    if (r == 0.0) return 32'h0;
    x = $realtobits(r);
    e = int'(x[62:52]) - 1023 + 127;
    if (e <= 0) return {x[63], 31'b0};
    if (e >= 255) return {x[63], 8'hFF, 23'b0};
    return {x[63], 8'(e), x[51:29]};
  endfunction

  // ---------------- behavioural model ----------------
  localparam int P_LOAD = 0, P_START = 1, P_WAIT = 2, P_OUT = 3;
  int            m_phase = P_LOAD;
  int            m_cnt = 0;
  bit            m_first = 0, m_err = 0, m_simerr = 0;
  logic [DL-1:0] m_res = '0;
  logic [DL-1:0] v1m [EN];
  logic [DL-1:0] v2m [EN];

  always @(negedge clk) begin
    if (!rst) begin
      m_phase = P_LOAD; m_cnt = 0; m_first = 0; m_err = 0; m_simerr = 0; m_res = '0;
      for (int i = 0; i < int'(EN); i++) begin v1m[i] = '0; v2m[i] = '0; end
    end
    chk("s_ready", 64'(s_ready), 64'(rst && m_phase == P_LOAD));
    chk("mac_start", 64'(mac_start), 64'(m_phase == P_START));
    chk("sim_valid", 64'(sim_valid), 64'(m_phase == P_OUT));
    chk("sim_result", 64'(sim_result), 64'(m_res));
    chk("sim_err", 64'(sim_err), 64'(m_simerr));
    chk_vec("v1", v1, v1m);
    chk_vec("v2", v2, v2m);
    if (mac_start) n_start++;
    if (rst) begin
      case (m_phase)
        P_LOAD: begin
          if (clr) begin
            m_cnt = 0; m_err = 0;
          end else if (s_valid) begin
            if (m_cnt < int'(EN)) v1m[m_cnt] = s_data; else v2m[m_cnt - int'(EN)] = s_data;
`ifdef EMB_NAN_CHECK_EN
            if (s_data[30:23] == 8'hFF) m_err = 1;
`endif
            if (m_cnt == int'(NW) - 1) begin
              m_cnt = 0;
              if (m_err) begin m_phase = P_OUT; m_res = 32'h7FC00000; m_simerr = 1; end
              else m_phase = P_START;
            end else m_cnt++;
          end
        end
        P_START: begin m_phase = P_WAIT; m_first = 1; end
        P_WAIT: begin
          if (m_first) m_first = 0;
          else if (mac_done) begin m_res = mac_result; m_phase = P_OUT; end
        end
        default: if (sim_ready) begin m_phase = P_LOAD; m_simerr = 0; m_err = 0; end
      endcase
    end
  end

  // ---------------- MAC model: done drops one cycle late (stale), then random latency ----------------
  bit         mac_busy = 0, mac_stale = 0;
  int         mac_lat = 0;
  logic [31:0] mac_dot = '0;
  always @(posedge clk) begin
    if (mac_start) begin
      real acc;
      acc = 0.0;
      for (int i = 0; i < int'(EN); i++) acc = acc + b2f(v1m[i]) * b2f(v2m[i]);
      mac_dot = f2b(acc);
      mac_busy = 1; mac_stale = 1; mac_lat = int'($urandom_range(0, 4));
    end else if (mac_busy) begin
      if (mac_stale) begin mac_done <= 1'b0; mac_stale = 0; end
      else if (mac_lat > 0) mac_lat--;
      else begin mac_done <= 1'b1; mac_result <= mac_dot; mac_busy = 0; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DL-1:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_data = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); ok = s_ready;
      step();
    end
    if (!ok) begin n_vec++; n_bad++; $display("FAIL send_timeout: got no accept expected accept"); end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_data = $urandom;
    repeat (n) step();
  endtask

  function automatic logic [DL-1:0] word(input int mode, input int k);
    case (mode)
      0: return (k < int'(EN)) ? 32'h3F800000 : 32'h40000000;
      1: return 32'(k);
      2: return {1'($urandom), 8'(120 + $urandom_range(0, 10)), 23'($urandom)};
      default: return 32'(1000 + k);
    endcase
  endfunction

  task automatic load_run(input int mode, input bit gaps, input int nan_at);
    for (int k = 0; k < int'(NW); k++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send((k == nan_at) ? 32'h7F800000 : word(mode, k));
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_out(input int hold, output logic [DL-1:0] res, output logic err);
    bit seen;
    seen = 0;
    res = '0; err = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk); seen = sim_valid;
    end
    if (!seen) begin n_vec++; n_bad++; $display("FAIL sim_valid_timeout: got 0 expected 1"); end
    res = sim_result; err = sim_err;
    step();
    repeat (hold) step();
    sim_ready = 1'b1; step(); sim_ready = 1'b0;
  endtask

  initial begin
    logic [DL-1:0] res;
    logic          err;
    logic [DL-1:0] e;
    int            s0;

    // 1: reset mid-stream
    repeat (3) step();
    rst = 1'b1; step();
    for (int k = 0; k < 30; k++) send(word(1, k));
    rst = 1'b0; #1;
    chk("rst_s_ready", 64'(s_ready), 64'h0);
    chk("rst_v1", 64'(v1 == '0), 64'h1);
    step(); step();
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk("release_s_ready", 64'(s_ready), 64'h1);
    step();

    // 2: 1.0 x 2.0 back-to-back
    s0 = n_start;
    load_run(0, 0, -1);
    finish_out(0, res, err);
    chk("ones_twos_result", 64'(res), 64'h43800000);
    chk("ones_twos_starts", 64'(n_start - s0), 64'd1);

    // 3: word k = k with gaps
    s0 = n_start;
    load_run(1, 1, -1);
    @(negedge clk);
    e = v1[5*DL +: DL];  chk("v1_elem5", 64'(e), 64'd5);
    e = v2[7*DL +: DL];  chk("v2_elem7", 64'(e), 64'd135);
    e = v2[127*DL +: DL]; chk("v2_elem127", 64'(e), 64'd255);
    finish_out(0, res, err);
    chk("index_starts", 64'(n_start - s0), 64'd1);

    // 4: random floats, downstream stalls 10 cycles
    load_run(2, 1, -1);
    finish_out(10, res, err);

    // 5: clr after 50 words (clr with a valid word), then a fresh load; clr in WAIT ignored
    for (int k = 0; k < 50; k++) send(word(1, k));
    clr = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF; step(); clr = 1'b0;
    s0 = n_start;
    load_run(3, 0, -1);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    e = v1[0 +: DL];  chk("clr_v1_elem0", 64'(e), 64'd1000);
    e = v1[DL +: DL]; chk("clr_v1_elem1", 64'(e), 64'd1001);
    finish_out(0, res, err);
    chk("clr_starts", 64'(n_start - s0), 64'd1);

    // 6: reset during WAIT
    load_run(2, 0, -1);
    step(); step();
    rst = 1'b0; #1;
    chk("wait_rst_valid", 64'(sim_valid), 64'h0);
    chk("wait_rst_v2", 64'(v2 == '0), 64'h1);
    step(); step();
    rst = 1'b1; step();

    // Inf word inside the load
    s0 = n_start;
    load_run(0, 0, 10);
    finish_out(2, res, err);
`ifdef EMB_NAN_CHECK_EN
    chk("nan_err", 64'(err), 64'h1);
    chk("nan_result", 64'(res), 64'h7FC00000);
    chk("nan_starts", 64'(n_start - s0), 64'd0);
`else
    chk("nan_err_off", 64'(err), 64'h0);
    chk("nan_starts_off", 64'(n_start - s0), 64'd1);
`endif

    // clean run afterwards: flag must not linger
    load_run(0, 1, -1);
    finish_out(1, res, err);
    chk("after_nan_result", 64'(res), 64'h43800000);
    chk("after_nan_err", 64'(err), 64'h0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
